nand_control_unit: RTL and testbench

- Multi-cycle control/register stage wrapped around the 16-bit ALU (u, op1, op0, zx, sw control set).
- Holds PC, A and D, fetches and decodes 16-bit instructions, and drives ALU operands and controls.
- Consumes the ALU result for register/memory writeback and jump evaluation.
- Talks to separate instruction and data memories over req/ack handshakes; the ALU itself stays external and combinational.

---
 rtl/nand_control_unit_pkg.sv | 47 ++++
 rtl/nand_jump_cond.sv | 25 ++
 rtl/nand_control_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_nand_control_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_control_unit_pkg.sv
// Shared constants, instruction bit positions and FSM state encoding for the NAND control unit.
// NAND_CU_HALT_DETECT_EN adds the HALT state to the encoding.
package nand_control_unit_pkg;

   localparam int DATA_W  = 16;

   localparam int CI_BIT  = 15;
   localparam int AM_BIT  = 12;
   localparam int U_BIT   = 10;
   localparam int OP1_BIT = 9;
   localparam int OP0_BIT = 8;
   localparam int ZX_BIT  = 7;
   localparam int SW_BIT  = 6;
   localparam int DA_BIT  = 5;
   localparam int DD_BIT  = 4;
   localparam int DM_BIT  = 3;
   localparam int LT_BIT  = 2;
   localparam int EQ_BIT  = 1;
   localparam int GT_BIT  = 0;

`ifdef NAND_CU_HALT_DETECT_EN
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DREAD  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_DWRITE = 3'd3,
      ST_HALT   = 3'd4
   } cu_state_e;
`else
   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DREAD  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_DWRITE = 2'd3
   } cu_state_e;
`endif

   // Sequential successor; wraps from all-ones back to zero.
   function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
      return pc + {{(DATA_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [DATA_W-1:0] const_value(input logic [DATA_W-1:0] ir);
      return {1'b0, ir[DATA_W-2:0]};
   endfunction

endpackage

// File: rtl/nand_jump_cond.sv
// Jump condition evaluator: compares a signed result against the lt/eq/gt mask.
// Purely combinational so it can be shared with a single-cycle core.
module nand_jump_cond
   import nand_control_unit_pkg::*;
(
   input  logic [DATA_W-1:0] res,
   input  logic              lt,
   input  logic              eq,
   input  logic              gt,
   output logic              jmp
);

   logic neg_s;
   logic zero_s;
   logic pos_s;

   // Classify the result sign and select the requested conditions.
   always_comb begin
      neg_s  = res[DATA_W-1];
      zero_s = (res == {DATA_W{1'b0}});
      pos_s  = !neg_s && !zero_s;
      jmp    = (lt && neg_s) || (eq && zero_s) || (gt && pos_s);
   end

endmodule

// File: rtl/nand_control_unit.sv
// Multi-cycle control/register stage around an external combinational 16-bit ALU.
// Optional halt detection is enabled by defining NAND_CU_HALT_DETECT_EN.
module nand_control_unit
   import nand_control_unit_pkg::*;
#(
   parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
)
(
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] alu_x,
   output logic [DATA_W-1:0] alu_y,
   output logic              alu_u,
   output logic              alu_op1,
   output logic              alu_op0,
   output logic              alu_zx,
   output logic              alu_sw,
   input  logic [DATA_W-1:0] alu_out,
   output logic              retire,
`ifdef NAND_CU_HALT_DETECT_EN
   output logic              halted,
`endif
   output logic [DATA_W-1:0] pc_q,
   output logic [DATA_W-1:0] a_q,
   output logic [DATA_W-1:0] d_q
);

   cu_state_e         state_r;
   cu_state_e         state_nxt_s;
   cu_state_e         done_state_s;

   logic [DATA_W-1:0] pc_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] d_r;
   logic [DATA_W-1:0] ir_r;
   logic [DATA_W-1:0] mq_r;
   logic [DATA_W-1:0] res_r;

   logic              imem_req_r;
   logic              dmem_req_r;
   logic              dmem_we_r;
   logic              retire_r;
   logic              imem_req_nxt_s;
   logic              dmem_req_nxt_s;
   logic              dmem_we_nxt_s;
   logic              retire_nxt_s;

   logic              fetch_done_s;
   logic              dread_done_s;
   logic              dwrite_done_s;
   logic              const_commit_s;
   logic              alu_commit_s;
   logic [DATA_W-1:0] commit_val_s;
   logic              jmp_s;

`ifdef NAND_CU_HALT_DETECT_EN
   logic              halt_s;
   logic              halted_r;
   logic              halted_nxt_s;
`endif

   // Handshake completions (acks only count while our request is up) and commit qualifiers.
   always_comb begin
      fetch_done_s   = (state_r == ST_FETCH)  && imem_req_r && imem_ack;
      dread_done_s   = (state_r == ST_DREAD)  && dmem_req_r && dmem_ack;
      dwrite_done_s  = (state_r == ST_DWRITE) && dmem_req_r && dmem_ack;
      const_commit_s = (state_r == ST_EXEC) && !ir_r[CI_BIT];
      alu_commit_s   = ((state_r == ST_EXEC) && ir_r[CI_BIT] && !ir_r[DM_BIT]) || dwrite_done_s;
      // A commit straight out of EXEC has not latched RES yet, so take the live ALU result.
      if (state_r == ST_DWRITE) begin
         commit_val_s = res_r;
      end else begin
         commit_val_s = alu_out;
      end
   end

   nand_jump_cond u_jump_cond (
      .res (commit_val_s),
      .lt  (ir_r[LT_BIT]),
      .eq  (ir_r[EQ_BIT]),
      .gt  (ir_r[GT_BIT]),
      .jmp (jmp_s)
   );

   // Destination state after a committing ALU instruction.
   always_comb begin
`ifdef NAND_CU_HALT_DETECT_EN
      halt_s = alu_commit_s && ir_r[LT_BIT] && ir_r[EQ_BIT] && ir_r[GT_BIT] &&
               (a_r == pc_r) && !ir_r[DA_BIT] && !ir_r[DD_BIT] && !ir_r[DM_BIT];
      if (halt_s) begin
         done_state_s = ST_HALT;
      end else begin
         done_state_s = ST_FETCH;
      end
`else
      done_state_s = ST_FETCH;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_FETCH: begin
            if (fetch_done_s) begin
               if (imem_rdata[CI_BIT] && imem_rdata[AM_BIT]) begin
                  state_nxt_s = ST_DREAD;
               end else begin
                  state_nxt_s = ST_EXEC;
               end
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DREAD: begin
            if (dread_done_s) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_DREAD;
            end
         end
         ST_EXEC: begin
            if (!ir_r[CI_BIT]) begin
               state_nxt_s = ST_FETCH;
            end else if (ir_r[DM_BIT]) begin
               state_nxt_s = ST_DWRITE;
            end else begin
               state_nxt_s = done_state_s;
            end
         end
         ST_DWRITE: begin
            if (dwrite_done_s) begin
               state_nxt_s = done_state_s;
            end else begin
               state_nxt_s = ST_DWRITE;
            end
         end
`ifdef NAND_CU_HALT_DETECT_EN
         ST_HALT: begin
            state_nxt_s = ST_HALT;
         end
`endif
         default: begin
            state_nxt_s = ST_FETCH;
         end
      endcase
   end

   // FSM outputs, computed from the next state so the request flops lead the state by nothing.
   always_comb begin
      imem_req_nxt_s = (state_nxt_s == ST_FETCH);
      dmem_req_nxt_s = (state_nxt_s == ST_DREAD) || (state_nxt_s == ST_DWRITE);
      dmem_we_nxt_s  = (state_nxt_s == ST_DWRITE);
      retire_nxt_s   = const_commit_s || alu_commit_s;
`ifdef NAND_CU_HALT_DETECT_EN
      halted_nxt_s   = (state_nxt_s == ST_HALT);
`endif
   end

   // Registered handshake/status outputs; reset clears them at once, abandoning any access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_req_r <= 1'b0;
         dmem_req_r <= 1'b0;
         dmem_we_r  <= 1'b0;
         retire_r   <= 1'b0;
`ifdef NAND_CU_HALT_DETECT_EN
         halted_r   <= 1'b0;
`endif
      end else begin
         imem_req_r <= imem_req_nxt_s;
         dmem_req_r <= dmem_req_nxt_s;
         dmem_we_r  <= dmem_we_nxt_s;
         retire_r   <= retire_nxt_s;
`ifdef NAND_CU_HALT_DETECT_EN
         halted_r   <= halted_nxt_s;
`endif
      end
   end

   // Architectural and pipeline registers; every commit reads the pre-instruction A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r  <= RESET_PC;
         a_r   <= {DATA_W{1'b0}};
         d_r   <= {DATA_W{1'b0}};
         ir_r  <= {DATA_W{1'b0}};
         mq_r  <= {DATA_W{1'b0}};
         res_r <= {DATA_W{1'b0}};
      end else begin
         if (fetch_done_s) begin
            ir_r <= imem_rdata;
         end
         if (dread_done_s) begin
            mq_r <= dmem_rdata;
         end
         if ((state_r == ST_EXEC) && ir_r[CI_BIT]) begin
            res_r <= alu_out;
         end
         if (const_commit_s) begin
            a_r  <= const_value(ir_r);
            pc_r <= pc_inc(pc_r);
         end else if (alu_commit_s) begin
            if (ir_r[DA_BIT]) begin
               a_r <= commit_val_s;
            end
            if (ir_r[DD_BIT]) begin
               d_r <= commit_val_s;
            end
            if (jmp_s) begin
               pc_r <= a_r;
            end else begin
               pc_r <= pc_inc(pc_r);
            end
         end
      end
   end

   assign imem_req   = imem_req_r;
   assign imem_addr  = pc_r;
   assign dmem_req   = dmem_req_r;
   assign dmem_we    = dmem_we_r;
   assign dmem_addr  = a_r;
   assign dmem_wdata = res_r;
   assign retire     = retire_r;
`ifdef NAND_CU_HALT_DETECT_EN
   assign halted     = halted_r;
`endif

   assign alu_x   = d_r;
   assign alu_y   = ir_r[AM_BIT] ? mq_r : a_r;
   assign alu_u   = ir_r[U_BIT];
   assign alu_op1 = ir_r[OP1_BIT];
   assign alu_op0 = ir_r[OP0_BIT];
   assign alu_zx  = ir_r[ZX_BIT];
   assign alu_sw  = ir_r[SW_BIT];

   assign pc_q = pc_r;
   assign a_q  = a_r;
   assign d_q  = d_r;

endmodule

// File: tb/tb_nand_control_unit.sv
// Self-checking bench for nand_control_unit: directed vector table, reset/halt sequences
// and randomized instructions checked against an instruction-level reference model.
module tb_nand_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic [15:0] alu_x, alu_y, alu_out;
   logic        alu_u, alu_op1, alu_op0, alu_zx, alu_sw;
   logic        retire;
   logic [15:0] pc_q, a_q, d_q;
`ifdef NAND_CU_HALT_DETECT_EN
   logic        halted;
`endif

   int cnt_run  = 0;
   int cnt_fail = 0;
   int cyc      = 0;
   int last_ret = 0;
   bit last_valid = 1'b0;

   logic [15:0] m_pc, m_a, m_d;
   logic [15:0] mem [logic [15:0]];

   typedef struct {
      logic [15:0] ir;
      int          wi;
      int          wd;
      logic [15:0] pc;
      logic [15:0] a;
      logic [15:0] d;
   } vec_t;
   vec_t vecs [20];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nand_control_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .alu_x(alu_x), .alu_y(alu_y), .alu_u(alu_u), .alu_op1(alu_op1), .alu_op0(alu_op0),
      .alu_zx(alu_zx), .alu_sw(alu_sw), .alu_out(alu_out),
      .retire(retire),
`ifdef NAND_CU_HALT_DETECT_EN
      .halted(halted),
`endif
      .pc_q(pc_q), .a_q(a_q), .d_q(d_q)
   );

   // External ALU: sw swaps operands, zx zeroes the left one, u selects arithmetic vs logic.
   function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                          input logic u, input logic op1, input logic op0,
                                          input logic zx, input logic sw);
      logic [15:0] l, r;
      l = sw ? y : x;
      r = sw ? x : y;
      if (zx) l = 16'h0000;
      case ({u, op1, op0})
         3'b100:  return l + r;
         3'b101:  return l + 16'h0001;
         3'b110:  return l - r;
         3'b111:  return l - 16'h0001;
         3'b000:  return l & r;
         3'b001:  return l | r;
         3'b010:  return l ^ r;
         default: return ~l;
      endcase
   endfunction

   assign alu_out = alu_fn(alu_x, alu_y, alu_u, alu_op1, alu_op0, alu_zx, alu_sw);

   function automatic logic [15:0] mem_rd(input logic [15:0] addr);
      if (mem.exists(addr)) return mem[addr];
      return addr ^ 16'hA5C3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cnt_run++;
      if (act !== exp) begin
         cnt_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      cnt_run++;
      cnt_fail++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   task automatic step();
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_imem_req", imem_req, 1'b0);
      chk("reset_retire", retire, 1'b0);
      rst_n = 1'b1;
      m_pc = 16'h0000;
      m_a = 16'h0000;
      m_d = 16'h0000;
      last_valid = 1'b0;
      chk("reset_pc", pc_q, 16'h0000);
      chk("reset_a", a_q, 16'h0000);
      chk("reset_d", d_q, 16'h0000);
   endtask

   // Starts at the current negedge: a fetch may be acknowledged in the cycle req rises.
   task automatic serve_imem(input logic [15:0] ir, input int w, output bit ok);
      int n = 0;
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
         if (t > 0) step();
         imem_rdata = 16'($urandom);
         if (imem_req) begin
            if (n == w) begin
               imem_ack = 1'b1;
               imem_rdata = ir;
               chk("imem_addr", imem_addr, m_pc);
               ok = 1'b1;
            end
            n++;
         end
      end
      if (!ok) timeout("imem_handshake");
   endtask

   task automatic serve_dmem(input bit we_exp, input logic [15:0] addr_exp,
                             input logic [15:0] wdata_exp, input int w, output bit ok);
      int n = 0;
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
         step();
         dmem_rdata = 16'($urandom);
         if (dmem_req) begin
            if (n == w) begin
               chk("dmem_we", dmem_we, we_exp);
               chk("dmem_addr", dmem_addr, addr_exp);
               if (we_exp) chk("dmem_wdata", dmem_wdata, wdata_exp);
               else dmem_rdata = mem_rd(addr_exp);
               dmem_ack = 1'b1;
               ok = 1'b1;
            end
            n++;
         end
      end
      if (!ok) timeout("dmem_handshake");
   endtask

   task automatic wait_retire(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
         step();
         if (retire) ok = 1'b1;
      end
      if (!ok) timeout("retire");
   endtask

   // One instruction: serve its memory traffic, then compare against the model's outcome.
   task automatic run_instr(input logic [15:0] ir, input int wi, input int wd);
      bit ok, ci, rd, wr, jmp;
      logic [15:0] y, res, a_old;
      int exp_cyc;
      ci = ir[15];
      rd = ci && ir[12];
      wr = ci && ir[3];
      serve_imem(ir, wi, ok);
      if (!ok) return;
      y = rd ? mem_rd(m_a) : m_a;
      if (rd) begin
         serve_dmem(1'b0, m_a, 16'h0000, wd, ok);
         if (!ok) return;
      end
      res = alu_fn(m_d, y, ir[10], ir[9], ir[8], ir[7], ir[6]);
      if (wr) begin
         serve_dmem(1'b1, m_a, res, wd, ok);
         if (!ok) return;
         mem[m_a] = res;
      end
      wait_retire(ok);
      if (!ok) return;
      if (!ci) begin
         m_a = {1'b0, ir[14:0]};
         m_pc = m_pc + 16'h0001;
      end else begin
         jmp = (ir[2] && $signed(res) < 0) || (ir[1] && res == 16'h0000) ||
               (ir[0] && $signed(res) > 0);
         a_old = m_a;
         if (ir[5]) m_a = res;
         if (ir[4]) m_d = res;
         m_pc = jmp ? a_old : m_pc + 16'h0001;
      end
      chk("model_pc", pc_q, m_pc);
      chk("model_a", a_q, m_a);
      chk("model_d", d_q, m_d);
      exp_cyc = (1 + wi) + (rd ? 1 + wd : 0) + 1 + (wr ? 1 + wd : 0);
      if (last_valid) chk("retire_period", cyc - last_ret, exp_cyc);
      last_ret = cyc;
      last_valid = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok, found;
      logic [15:0] ir;

      vecs[0]  = '{16'h1234, 0, 0, 16'h0001, 16'h1234, 16'h0000};
      vecs[1]  = '{16'h0007, 1, 0, 16'h0002, 16'h0007, 16'h0000};
      vecs[2]  = '{16'h8490, 0, 0, 16'h0003, 16'h0007, 16'h0007};
      vecs[3]  = '{16'h0004, 2, 0, 16'h0004, 16'h0004, 16'h0007};
      vecs[4]  = '{16'h8490, 0, 0, 16'h0005, 16'h0004, 16'h0004};
      vecs[5]  = '{16'h000A, 0, 0, 16'h0006, 16'h000A, 16'h0004};
      vecs[6]  = '{16'h9408, 0, 3, 16'h0007, 16'h000A, 16'h0004};
      vecs[7]  = '{16'h8790, 0, 0, 16'h0008, 16'h000A, 16'hFFFF};
      vecs[8]  = '{16'h0040, 0, 0, 16'h0009, 16'h0040, 16'hFFFF};
      vecs[9]  = '{16'h84C1, 0, 0, 16'h000A, 16'h0040, 16'hFFFF};
      vecs[10] = '{16'h84C4, 1, 0, 16'h0040, 16'h0040, 16'hFFFF};
      vecs[11] = '{16'h0037, 0, 0, 16'h0041, 16'h0037, 16'hFFFF};
      vecs[12] = '{16'h8490, 0, 0, 16'h0042, 16'h0037, 16'h0037};
      vecs[13] = '{16'h0014, 0, 0, 16'h0043, 16'h0014, 16'h0037};
      vecs[14] = '{16'h84E9, 0, 2, 16'h0014, 16'h0037, 16'h0037};
      vecs[15] = '{16'h87A0, 0, 0, 16'h0015, 16'hFFFF, 16'h0037};
      vecs[16] = '{16'h84C7, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0037};
      vecs[17] = '{16'h0001, 0, 0, 16'h0000, 16'h0001, 16'h0037};
      vecs[18] = '{16'h0014, 0, 0, 16'h0001, 16'h0014, 16'h0037};
      vecs[19] = '{16'h9490, 0, 1, 16'h0002, 16'h0014, 16'h0037};

      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      imem_rdata = 16'h0000;
      dmem_rdata = 16'h0000;
      mem[16'h000A] = 16'h0003;

      do_reset();
      for (int i = 0; i < 20; i++) begin
         run_instr(vecs[i].ir, vecs[i].wi, vecs[i].wd);
         chk($sformatf("vec%0d_pc", i), pc_q, vecs[i].pc);
         chk($sformatf("vec%0d_a", i), a_q, vecs[i].a);
         chk($sformatf("vec%0d_d", i), d_q, vecs[i].d);
      end
      chk("mem_000a", mem_rd(16'h000A), 16'h0007);

      // Reset while a write is pending with ack withheld.
      do_reset();
      serve_imem(16'h84C8, 0, ok);
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         step();
         if (dmem_req && dmem_we) found = 1'b1;
      end
      chk("dwrite_req_seen", found, 1'b1);
      repeat (2) step();
      chk("dwrite_req_held", dmem_req, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_dmem_req", dmem_req, 1'b0);
      chk("async_rst_dmem_we", dmem_we, 1'b0);
      chk("async_rst_imem_req", imem_req, 1'b0);
      chk("async_rst_retire", retire, 1'b0);
      do_reset();
      run_instr(16'h0123, 0, 0);
      chk("after_rst_a", a_q, 16'h0123);
      chk("after_rst_pc", pc_q, 16'h0001);

      // Randomized instructions against the model.
      for (int i = 0; i < 300; i++) begin
         ir = 16'($urandom);
         ir[15] = ($urandom_range(0, 3) != 0);
         if (ir[15] && ir[2:0] == 3'b111 && ir[5:3] == 3'b000) ir[0] = 1'b0;
         run_instr(ir, $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // Self-jump with A == PC and no destinations.
      do_reset();
      run_instr(16'h0001, 0, 0);
`ifdef NAND_CU_HALT_DETECT_EN
      run_instr(16'h84C7, 0, 0);
      repeat (3) step();
      chk("halted", halted, 1'b1);
      chk("halt_no_imem_req", imem_req, 1'b0);
      chk("halt_no_dmem_req", dmem_req, 1'b0);
`else
      run_instr(16'h84C7, 0, 0);
      run_instr(16'h84C7, 0, 0);
      chk("self_loop_pc", pc_q, 16'h0001);
`endif

      $display("[TB] %0d tests run, %0d failed", cnt_run, cnt_fail);
      $finish;
   end

endmodule
